// File: rtl/seg_scan_mux_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
// Pure declarations; no timing or flow-control behaviour of its own.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam int   DIG_N   = 4;
    localparam seg_t SEG_OFF = '0;

    // Converts a logical "lit/selected" bit into the pin level for the board wiring.
    function automatic logic apply_pol(input logic value, input logic active_low);
        return value ^ active_low;
    endfunction

endpackage

// File: rtl/seg_scan_mux_tick_divider.sv
// Free-running modulo-DIV counter with a one-cycle pulse on its last count.
// Pulse is combinational from the count (same cycle); never stalls.
module tick_divider #(
    parameter int DIV = 20,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    if (DIV < 1) begin : g_bad_div
        $error("tick_divider: DIV must be at least 1");
    end

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// 4-digit multiplexed 7-segment driver with per-frame input latching, dead-time blanking, blink and DP.
// Pins are registered (1-cycle latency from internal scan state); no backpressure, scan is free-running.
module seg_scan_mux
    import disp_pkg::*;
#(
    parameter int CLK_HZ         = 12_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYC      = 120,
    parameter int BLINK_HZ       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dig0,
    input  logic [6:0] dig1,
    input  logic [6:0] dig2,
    input  logic [6:0] dig3,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    input  logic       en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int DIG_CYC = CLK_HZ / SCAN_HZ;
    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW      = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1;

    localparam seg_t       SEG_IDLE = {7{SEG_ACTIVE_LOW}};
    localparam logic       DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [3:0] AN_IDLE  = {4{AN_ACTIVE_LOW}};

    if (BLANK_CYC >= DIG_CYC || DIG_CYC < 2) begin : g_bad_timing
        $error("seg_scan_mux: need DIG_CYC >= 2 and BLANK_CYC < DIG_CYC");
    end

    // Scan position and frame-latched display content
    logic [PW-1:0]    pre;
    logic [1:0]       idx;
    seg_t             shadow [DIG_N];
    logic [DIG_N-1:0] shadow_blink;
    logic [DIG_N-1:0] shadow_dp;
    logic             blink_ph;
    logic             blink_wrap;

    logic pre_wrap;
    logic frame_start;
    logic frame_end;

    assign pre_wrap    = (pre == PW'(DIG_CYC - 1));
    assign frame_start = (pre == '0) && (idx == 2'd0);
    assign frame_end   = pre_wrap && (idx == 2'd3);

    tick_divider #(
        .DIV (HALF)
    ) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .tick (blink_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_ph <= 1'b0;
        end else if (blink_wrap) begin
            blink_ph <= ~blink_ph;
        end
    end

    // Disabled display parks at the top of a frame so re-enable starts with a fresh latch.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre <= '0;
            idx <= 2'd0;
        end else if (pre_wrap) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIG_N; i++) begin
                shadow[i] <= SEG_OFF;
            end
            shadow_blink <= '0;
            shadow_dp    <= '0;
        end else if (en && frame_start) begin
            shadow[0]    <= dig0;
            shadow[1]    <= dig1;
            shadow[2]    <= dig2;
            shadow[3]    <= dig3;
            shadow_blink <= blink_mask;
            shadow_dp    <= dp_mask;
        end
    end

    // Logical (active-high) view of what the current slot should show
    logic [DIG_N-1:0] an_on;
    seg_t             seg_on;
    logic             dp_on;

    always_comb begin
        an_on  = '0;
        seg_on = SEG_OFF;
        dp_on  = 1'b0;
        if (pre >= PW'(BLANK_CYC)) begin
            an_on[idx] = 1'b1;
            if (!(blink_ph && shadow_blink[idx])) begin
                seg_on = shadow[idx];
                dp_on  = shadow_dp[idx];
            end
        end
    end

    logic [3:0] an_pin;
    seg_t       seg_pin;
    logic       dp_pin;

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            seg_pin[i] = apply_pol(seg_on[i], SEG_ACTIVE_LOW);
        end
        for (int i = 0; i < DIG_N; i++) begin
            an_pin[i] = apply_pol(an_on[i], AN_ACTIVE_LOW);
        end
        dp_pin = apply_pol(dp_on, SEG_ACTIVE_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            an         <= AN_IDLE;
            seg        <= SEG_IDLE;
            dp         <= DP_IDLE;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_pin;
            seg        <= seg_pin;
            dp         <= dp_pin;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized scoreboard bench for seg_scan_mux using a cycle-count reference model.
module tb_seg_scan_mux;

    localparam int DIG_CYC = 10;
    localparam int BLANK   = 2;
    localparam int HALF    = 20;
    localparam int FRAME   = 4 * DIG_CYC;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } pins_t;

    localparam pins_t IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [6:0] din [4];
    logic [3:0] blink_mask = '0;
    logic [3:0] dp_mask    = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int tests  = 0;
    int failed = 0;

    pins_t exp_q[$];

    // Reference model state: cycles since frame restart, cycles since reset, latched content
    int         m_t = 0;
    int         m_b = 0;
    logic [6:0] m_sh [4];
    logic [3:0] m_bl = '0;
    logic [3:0] m_dp = '0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .BLANK_CYC      (BLANK),
        .BLINK_HZ       (25),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dig0       (din[0]),
        .dig1       (din[1]),
        .dig2       (din[2]),
        .dig3       (din[3]),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .en         (en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    // Predict the pins after the coming edge from the inputs now applied, then advance one cycle.
    task automatic tick();
        pins_t e;
        int    p;
        int    i;
        bit    ph;
        e = IDLE;
        if (rst) begin
            m_t = 0;
            m_b = 0;
            for (int k = 0; k < 4; k++) m_sh[k] = 7'h00;
            m_bl = '0;
            m_dp = '0;
        end else begin
            ph  = ((m_b / HALF) % 2) == 1;
            m_b = m_b + 1;
            if (!en) begin
                m_t = 0;
            end else begin
                p = m_t % DIG_CYC;
                i = (m_t / DIG_CYC) % 4;
                if (p >= BLANK) begin
                    e.an = ~(4'b0001 << i);
                    if (!(ph && m_bl[i])) begin
                        e.seg = ~m_sh[i];
                        e.dp  = ~m_dp[i];
                    end
                end
                e.ft = (m_t % FRAME) == FRAME - 1;
                if (m_t % FRAME == 0) begin
                    for (int k = 0; k < 4; k++) m_sh[k] = din[k];
                    m_bl = blink_mask;
                    m_dp = dp_mask;
                end
                m_t = m_t + 1;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: each cycle the DUT presents pins; compare against the oldest prediction.
    initial begin
        pins_t e;
        pins_t got;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = '{an: an, seg: seg, dp: dp, ft: frame_tick};
                tests++;
                if (got !== e) begin
                    failed++;
                    $display("FAIL pins @%0t: got an=%h seg=%h dp=%b ft=%b, want an=%h seg=%h dp=%b ft=%b",
                             $time, got.an, got.seg, got.dp, got.ft, e.an, e.seg, e.dp, e.ft);
                end
            end
        end
    end

    initial begin
        int guard;
        din[0] = 7'h3F;
        din[1] = 7'h06;
        din[2] = 7'h5B;
        din[3] = 7'h4F;
        en  = 1'b1;
        rst = 1'b1;
        run(3);

        // Static scan, then a mid-frame change of digit 1 during the digit-2 slot
        rst = 1'b0;
        run(2 * FRAME + 25);
        din[1] = 7'h7F;
        run(60);

        blink_mask = 4'b0010;
        dp_mask    = 4'b0010;
        run(3 * FRAME);

        // Disable in the middle of digit 2's slot
        guard = 0;
        while (m_t % FRAME != 25 && guard < FRAME) begin
            tick();
            guard++;
        end
        en = 1'b0;
        run(15);
        din[0]     = 7'h6D;
        blink_mask = 4'b0001;
        en         = 1'b1;
        run(FRAME + 20);

        // Reset pulse during digit 3's slot
        guard = 0;
        while (m_t % FRAME != 35 && guard < FRAME) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * FRAME + 10);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) din[$urandom_range(0, 3)] = 7'($urandom);
            if ($urandom_range(0, 79) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 79) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 119) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        en  = 1'b1;
        run(5);

        @(negedge clk);
        @(negedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d predictions unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
